// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared between the issue stage and the ALU.
//   alu_op_e    - ALU operation select carried on sel_op_o.
//   OPC_*       - RV32I major opcodes decoded by the issue stage.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: one busy bit per architectural register.
//   clk, rst          clock, synchronous active-high reset
//   set_en, set_addr  mark a register as having an outstanding producer
//   clr_en, clr_addr  writeback of a register completed
//   addr_a, addr_b    combinational lookup addresses
//   busy_a, busy_b    registered busy bit of the looked-up registers
module issue_scoreboard #(
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic          busy_a,
    output logic          busy_b
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a new producer wins over a retiring one;
    // x0 is hardwired and never tracked.
    always_comb begin
        busy_d = busy_r;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_r <= '0;
        else     busy_r <= busy_d;
    end

    assign busy_a = busy_r[addr_a];
    assign busy_b = busy_r[addr_b];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue stage feeding the ALU operand interface.
//   clk_i, rst_i                  clock, synchronous active-high reset
//   instr_i/_valid_i/_ready_o     incoming instruction handshake
//   rs1/rs2_addr_o, rs1/rs2_data_i  combinational register-file read
//   oper1_o, oper2_o, sel_op_o,
//   rd_addr_o, illegal_o          registered issue slot contents
//   issue_valid_o, issue_ready_i  issue slot handshake
//   wb_valid_i, wb_rd_i           writeback completion, clears busy bit
//   flush_i                       squash slot and block incoming instruction
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    output logic [AW-1:0]   rs1_addr_o,
    output logic [AW-1:0]   rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic [XLEN-1:0] oper1_o,
    output logic [XLEN-1:0] oper2_o,
    output alu_op_e         sel_op_o,
    output logic [AW-1:0]   rd_addr_o,
    output logic            illegal_o,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_rd_i,
    input  logic            flush_i
);

    typedef struct packed {
        alu_op_e          sel;
        logic [XLEN-1:0]  oper1;
        logic [XLEN-1:0]  oper2;
        logic [AW-1:0]    rd;
        logic             illegal;
        logic             use1;
        logic             use2;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr,
                                    input logic [XLEN-1:0] rs1v,
                                    input logic [XLEN-1:0] rs2v);
        dec_t                   d;
        logic [2:0]             f3;
        logic [6:0]             f7;
        logic signed [XLEN-1:0] imm_i;
        logic [XLEN-1:0]        shamt;
        d     = '0;
        f3    = instr[14:12];
        f7    = instr[31:25];
        imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
        shamt = XLEN'(instr[24:20]);
        case (instr[6:0])
            OPC_OP: begin
                d.use1  = 1'b1;
                d.use2  = 1'b1;
                d.oper1 = rs1v;
                d.oper2 = rs2v;
                d.rd    = instr[7 +: AW];
                case (f3)
                    3'd0:    d.sel = f7[5] ? ALU_SUB : ALU_ADD;
                    3'd1:    d.sel = ALU_SLL;
                    3'd2:    d.sel = ALU_SLT;
                    3'd3:    d.sel = ALU_SLTU;
                    3'd4:    d.sel = ALU_XOR;
                    3'd5:    d.sel = f7[5] ? ALU_SRA : ALU_SRL;
                    3'd6:    d.sel = ALU_OR;
                    default: d.sel = ALU_AND;
                endcase
                // Only ADD/SUB and SRL/SRA have an alternate f7 encoding.
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
                    d.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                d.use1  = 1'b1;
                d.oper1 = rs1v;
                d.oper2 = imm_i;
                d.rd    = instr[7 +: AW];
                case (f3)
                    3'd0:    d.sel = ALU_ADD;
                    3'd1:    begin d.sel = ALU_SLL; d.oper2 = shamt; end
                    3'd2:    d.sel = ALU_SLT;
                    3'd3:    d.sel = ALU_SLTU;
                    3'd4:    d.sel = ALU_XOR;
                    3'd5:    begin d.sel = instr[30] ? ALU_SRA : ALU_SRL; d.oper2 = shamt; end
                    3'd6:    d.sel = ALU_OR;
                    default: d.sel = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                d.sel   = ALU_ADD;
                d.oper2 = XLEN'({instr[31:12], 12'b0});
                d.rd    = instr[7 +: AW];
            end
            default: d.illegal = 1'b1;
        endcase
        // An illegal slot carries no payload so it can never alias a real producer.
        if (d.illegal) begin
            d.sel   = ALU_ADD;
            d.oper1 = '0;
            d.oper2 = '0;
            d.rd    = '0;
        end
        return d;
    endfunction

    dec_t            dec_p0;
    logic            busy_rs1_p0;
    logic            busy_rs2_p0;
    logic            haz1_p0;
    logic            haz2_p0;
    logic            fire_p0;
    logic            issue_hs;
    logic            sb_set;

    logic            vld_p1;
    logic [XLEN-1:0] oper1_p1;
    logic [XLEN-1:0] oper2_p1;
    alu_op_e         sel_p1;
    logic [AW-1:0]   rd_p1;
    logic            illegal_p1;

    // ---- stage p0: decode, register-file read, hazard check ----
    assign rs1_addr_o = instr_i[15 +: AW];
    assign rs2_addr_o = instr_i[20 +: AW];

    always_comb dec_p0 = decode(instr_i, rs1_data_i, rs2_data_i);

    // The slot's own rd covers the producer that has not yet set its busy bit.
    assign haz1_p0 = dec_p0.use1 && (rs1_addr_o != '0) &&
                     (busy_rs1_p0 || (vld_p1 && rd_p1 == rs1_addr_o));
    assign haz2_p0 = dec_p0.use2 && (rs2_addr_o != '0) &&
                     (busy_rs2_p0 || (vld_p1 && rd_p1 == rs2_addr_o));

    assign instr_ready_o = !(haz1_p0 || haz2_p0) && !flush_i && (!vld_p1 || issue_ready_i);
    assign fire_p0       = instr_valid_i && instr_ready_o;

    // A flushed slot is squashed even if the consumer accepts it this cycle.
    assign issue_hs = vld_p1 && issue_ready_i && !flush_i;
    assign sb_set   = issue_hs && !illegal_p1 && (rd_p1 != '0);

    issue_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk      (clk_i),
        .rst      (rst_i),
        .set_en   (sb_set),
        .set_addr (rd_p1),
        .clr_en   (wb_valid_i),
        .clr_addr (wb_rd_i),
        .addr_a   (rs1_addr_o),
        .addr_b   (rs2_addr_o),
        .busy_a   (busy_rs1_p0),
        .busy_b   (busy_rs2_p0)
    );

    // ---- stage p1: issue slot ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1     <= 1'b0;
            oper1_p1   <= '0;
            oper2_p1   <= '0;
            sel_p1     <= ALU_ADD;
            rd_p1      <= '0;
            illegal_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (fire_p0) begin
            vld_p1     <= 1'b1;
            oper1_p1   <= dec_p0.oper1;
            oper2_p1   <= dec_p0.oper2;
            sel_p1     <= dec_p0.sel;
            rd_p1      <= dec_p0.rd;
            illegal_p1 <= dec_p0.illegal;
        end else if (issue_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign issue_valid_o = vld_p1;
    assign oper1_o       = oper1_p1;
    assign oper2_o       = oper2_p1;
    assign sel_op_o      = sel_p1;
    assign rd_addr_o     = rd_p1;
    assign illegal_o     = illegal_p1;

endmodule
